mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_pkg.sv | 25 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority scan: first requester after 'last' (wrapping, 'last' itself lowest).
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             pick_vld,
    output logic [SEL_W-1:0] pick_idx
);

    logic [SEL_W-1:0] cand_s;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand_s   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand_s = last + 2'(k);
            if (req[cand_s]) begin
                pick_vld = 1'b1;
                pick_idx = cand_s;
            end else begin
                pick_vld = pick_vld;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux.
// Optional forced hand-off after MAX_HOLD cycles: define HOLD_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;

    logic [SEL_W-1:0] owner_idx_s;
    logic [SEL_W-1:0] scan_last_s;
    logic             others_s;
    logic             timeout_s;
    logic             release_s;
    logic             pick_vld_s;
    logic [SEL_W-1:0] pick_idx_s;

    assign owner_idx_s = onehot_to_idx(grant_q);
    assign others_s    = |(req & ~grant_q);
    // While busy the scan starts after the current owner, so it is lowest priority at hand-off.
    assign scan_last_s = (state_q == BUSY) ? owner_idx_s : last_q;
    assign release_s   = (state_q == BUSY) && (!(|(req & grant_q)) || timeout_s);

`ifdef HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    assign timeout_s = (hold_cnt_q == 8'(MAX_HOLD - 1)) && others_s;

    // Cycles under the current owner; restarts on any grant change, saturates when nobody waits.
    always_comb begin
        if (grant_d != grant_q) begin
            hold_cnt_d = 8'd0;
        end else if ((state_q == BUSY) && (hold_cnt_q < 8'(MAX_HOLD - 1))) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic [7:0] unused_max_hold_s;

    assign timeout_s         = 1'b0;
    assign unused_max_hold_s = 8'(MAX_HOLD) & {7'd0, others_s};
`endif

    rr_pick4 u_pick (
        .req      (req),
        .last     (scan_last_s),
        .pick_vld (pick_vld_s),
        .pick_idx (pick_idx_s)
    );

    // Next-state and next-output decision.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_vld_s) begin
                    state_d = BUSY;
                    grant_d = idx_to_onehot(pick_idx_s);
                    sel_d   = pick_idx_s;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    last_d = owner_idx_s;
                    if (pick_vld_s) begin
                        grant_d = idx_to_onehot(pick_idx_s);
                        sel_d   = pick_idx_s;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; last owner resets to 3 so requester 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: behavioural round-robin model plus directed literal pins.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner;   // -1 when nobody owns the mux
    int m_last;
    int m_sel;
    int m_hold;
    int m_w;
    bit m_hand;

    function automatic int rr_winner(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            m_w = rr_winner(req, m_last);
            if (m_w >= 0) begin
                m_owner = m_w; m_sel = m_w; m_hold = 0;
            end
        end else begin
            m_hand = (req[m_owner] == 1'b0);
`ifdef HOLD_TIMEOUT_EN
            if (m_hold == MAX_HOLD - 1 && (req & ~(4'b0001 << m_owner)) != 4'b0000) m_hand = 1'b1;
`endif
            if (m_hand) begin
                m_last = m_owner;
                m_w = rr_winner(req & ~(4'b0001 << m_owner), m_owner);
                m_hold = 0;
                if (m_w >= 0) begin
                    m_owner = m_w; m_sel = m_w;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [3:0] eg;
            eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            chk("model_grant", {4'd0, grant}, {4'd0, eg});
            chk("model_sel", {6'd0, sel}, 8'(m_sel));
            chk("model_valid", {7'd0, valid}, {7'd0, m_owner >= 0});
            chk("onehot", 8'($countones(grant) <= 1), 8'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] r);
        req = r;
        @(negedge clk);
    endtask

    logic [3:0] seen [5];
    logic [3:0] prev_g;
    int nseen, cnt, run_len, nruns, bad_runs;
    bit idle_seen;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        chk("reset_grant", {4'd0, grant}, 8'h00);
        chk("reset_sel", {6'd0, sel}, 8'h00);
        chk("reset_valid", {7'd0, valid}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            chk("idle_grant", {4'd0, grant}, 8'h00);
            chk("idle_valid", {7'd0, valid}, 8'h00);
        end

        // All request; each owner drops for one cycle after holding three.
        req = 4'hF; prev_g = 4'b0000; cnt = 0; nseen = 0; idle_seen = 1'b0;
        for (int c = 0; c < 40 && nseen < 5; c++) begin
            @(negedge clk);
            if (grant != prev_g) begin
                if (nseen < 5) seen[nseen] = grant;
                nseen++; prev_g = grant; cnt = 1;
            end else begin
                cnt++;
            end
            if (!valid && nseen > 0) idle_seen = 1'b1;
            req = (cnt == 3) ? (4'hF & ~grant) : 4'hF;
        end
        chk("rr_count", 8'(nseen), 8'd5);
        chk("rr_g0", {4'd0, seen[0]}, 8'h01);
        chk("rr_g1", {4'd0, seen[1]}, 8'h02);
        chk("rr_g2", {4'd0, seen[2]}, 8'h04);
        chk("rr_g3", {4'd0, seen[3]}, 8'h08);
        chk("rr_g4", {4'd0, seen[4]}, 8'h01);
        chk("rr_no_bubble", {7'd0, idle_seen}, 8'h00);

        // Single requester 2, then release.
        step(4'b0000);
        step(4'b0000);
        step(4'b0100);
        chk("single_grant", {4'd0, grant}, 8'h04);
        chk("single_sel", {6'd0, sel}, 8'h02);
        step(4'b0100);
        step(4'b0000);
        chk("drop_grant", {4'd0, grant}, 8'h00);
        chk("drop_valid", {7'd0, valid}, 8'h00);
        chk("drop_sel_held", {6'd0, sel}, 8'h02);

        // Owner 1 drops for one cycle while 0 waits.
        step(4'b0010);
        chk("own1_grant", {4'd0, grant}, 8'h02);
        step(4'b0011);
        step(4'b0011);
        step(4'b0001);
        chk("handoff_to0", {4'd0, grant}, 8'h01);
        step(4'b0011);
        step(4'b0011);
        step(4'b0011);
        chk("hold0", {4'd0, grant}, 8'h01);
        step(4'b0010);
        chk("regrant1", {4'd0, grant}, 8'h02);

        // Asynchronous reset mid-grant.
        step(4'b1000);
        chk("own3_grant", {4'd0, grant}, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grant", {4'd0, grant}, 8'h00);
        chk("async_sel", {6'd0, sel}, 8'h00);
        chk("async_valid", {7'd0, valid}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001);
        chk("post_rst_first0", {4'd0, grant}, 8'h01);
        step(4'b1000);
        chk("post_rst_to3", {4'd0, grant}, 8'h08);

        // Two requesters held continuously.
        step(4'b0000);
        req = 4'b0011; prev_g = 4'b0000; run_len = 0; nruns = 0; bad_runs = 0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            if (grant != prev_g) begin
                if (nruns >= 2 && run_len != MAX_HOLD) bad_runs++;
                nruns++; run_len = 1; prev_g = grant;
            end else begin
                run_len++;
            end
        end
`ifdef HOLD_TIMEOUT_EN
        chk("timeout_runs", 8'(nruns), 8'd6);
        chk("timeout_len", 8'(bad_runs), 8'd0);
`else
        chk("no_timeout_runs", 8'(nruns), 8'd1);
`endif
        for (int c = 0; c < 30; c++) step(4'b0001);
        chk("solo_hold", {4'd0, grant}, 8'h01);

        // Randomized traffic; owner tends to keep requesting.
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r = r | grant;
            if ($urandom_range(0, 9) == 0) r = 4'b0000;
            step(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
